// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - shared state type, defaults and sizing helper for the frame copy sequencer
package ov7670_pkg;

  localparam int ADDR_W_DEF = 19;
  localparam int RD_LAT_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COPY,
    ST_DRAIN,
    ST_LENET_REQ,
    ST_LENET_WAIT
  } seq_state_t;

  function automatic bit fits_addr(input int pixels, input int addr_w);
    return longint'(pixels) <= (longint'(1) << addr_w);
  endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// rtl/frame_sequencer_if.sv - control, memory and inference handshake signals of the frame sequencer
interface frame_sequencer_if
  import ov7670_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              frame_start;
  logic              pause;
  logic              lenet_mode;
  logic              lenet_ready;
  logic              lenet_done;
  logic              ovr_clr;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic              lenet_start;
  logic              busy;
  logic [7:0]        frame_cnt;
  logic              overrun;

  modport master (
    input  frame_start, pause, lenet_mode, lenet_ready, lenet_done, ovr_clr,
    output rd_addr, rd_en, wr_addr, wr_en, lenet_start, busy, frame_cnt, overrun
  );

  modport slave (
    output frame_start, pause, lenet_mode, lenet_ready, lenet_done, ovr_clr,
    input  rd_addr, rd_en, wr_addr, wr_en, lenet_start, busy, frame_cnt, overrun
  );

endinterface

// File: rtl/seq_delay_line.sv
// rtl/seq_delay_line.sv - fixed-latency valid+address delay matching the source memory read latency
module seq_delay_line #(
  parameter int W   = 19,
  parameter int LAT = 2
) (
  input  logic         clk25,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_addr,
  output logic         out_valid,
  output logic [W-1:0] out_addr,
  output logic         pending
);

  logic [LAT-1:0] vld;
  logic [W-1:0]   adr [LAT];

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < LAT; i++) adr[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      adr[0] <= in_addr;
      for (int i = 1; i < LAT; i++) begin
        vld[i] <= vld[i-1];
        adr[i] <= adr[i-1];
      end
    end
  end

  assign out_valid = vld[LAT-1];
  assign out_addr  = adr[LAT-1];

  // The last stage is the write happening this cycle, so it does not count as outstanding.
  if (LAT > 1) begin : g_pending
    assign pending = |vld[LAT-2:0];
  end else begin : g_no_pending
    assign pending = 1'b0;
  end

endmodule

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - copies one captured frame to display memory, then optionally starts inference
module frame_sequencer
  import ov7670_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input logic               clk25,
  input logic               rst,
  frame_sequencer_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

  if (!fits_addr(WIDTH * HEIGHT, ADDR_W)) begin : g_size_check
    $error("frame_sequencer: WIDTH*HEIGHT does not fit in ADDR_W address bits");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_lat_check
    $error("frame_sequencer: RD_LAT must be within 1..4");
  end

  seq_state_t        state, state_n;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_n;
  logic [ADDR_W-1:0] next_q, next_n;
  logic              rd_en_q, rd_en_n;
  logic [7:0]        cnt_q, cnt_n;
  logic              busy_q, start_q, ovr_q;
  logic              pending;

  // next_q is the address still to be issued; rd_addr_q keeps the last issued one through a pause.
  always_comb begin
    state_n   = state;
    rd_en_n   = 1'b0;
    rd_addr_n = rd_addr_q;
    next_n    = next_q;
    cnt_n     = cnt_q;
    case (state)
      ST_IDLE: begin
        if (bus.frame_start && !bus.pause) begin
          state_n   = ST_COPY;
          rd_en_n   = 1'b1;
          rd_addr_n = '0;
          next_n    = ADDR_W'(1);
        end
      end
      ST_COPY: begin
        if (rd_en_q && rd_addr_q == LAST_ADDR) begin
          state_n   = ST_DRAIN;
          rd_addr_n = '0;
          next_n    = '0;
        end else if (!bus.pause) begin
          rd_en_n   = 1'b1;
          rd_addr_n = next_q;
          next_n    = next_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (!pending) begin
          cnt_n   = cnt_q + 8'd1;
          state_n = bus.lenet_mode ? ST_LENET_REQ : ST_IDLE;
        end
      end
      ST_LENET_REQ: begin
        if (bus.lenet_ready) state_n = ST_LENET_WAIT;
      end
      ST_LENET_WAIT: begin
        if (bus.lenet_done) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rd_addr_q <= '0;
      next_q    <= '0;
      rd_en_q   <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state     <= state_n;
      rd_addr_q <= rd_addr_n;
      next_q    <= next_n;
      rd_en_q   <= rd_en_n;
      cnt_q     <= cnt_n;
      busy_q    <= (state_n != ST_IDLE);
      start_q   <= (state_n == ST_LENET_REQ);
      if (bus.frame_start && state != ST_IDLE) ovr_q <= 1'b1;
      else if (bus.ovr_clr)                    ovr_q <= 1'b0;
    end
  end

  seq_delay_line #(
    .W   (ADDR_W),
    .LAT (RD_LAT)
  ) u_delay (
    .clk25     (clk25),
    .rst       (rst),
    .in_valid  (rd_en_q),
    .in_addr   (rd_addr_q),
    .out_valid (bus.wr_en),
    .out_addr  (bus.wr_addr),
    .pending   (pending)
  );

  assign bus.rd_addr     = rd_addr_q;
  assign bus.rd_en       = rd_en_q;
  assign bus.lenet_start = start_q;
  assign bus.busy        = busy_q;
  assign bus.frame_cnt   = cnt_q;
  assign bus.overrun     = ovr_q;

endmodule
